// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one add/sub/and/or ALU among NREQ requesters; one registered result slot.
// Optional NZCV flags output enabled by defining ALU_ARB_FLAGS_EN.
//
// state | meaning
// EMPTY | result slot holds no valid result (rsp_valid = 0)
// FULL  | result slot holds a result awaiting rsp_ready (rsp_valid = 1)
module alu_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    input  logic [NREQ*2-1:0]   req_ctl,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [N-1:0]        rsp_result,
    output logic [IDW-1:0]      rsp_id
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic [3:0]          rsp_flags
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t    state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic           free;
    logic           found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   scan;

    assign rsp_valid = (state == FULL);
    assign free      = !rsp_valid || rsp_ready;

    // Scan starts at ptr and wraps; the grant is withheld while reset is asserted.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        if (free && reset_n) begin
            for (int k = 0; k < NREQ; k++) begin
                scan = {1'b0, ptr} + (IDW+1)'(k);
                if (scan >= (IDW+1)'(NREQ)) begin
                    scan = scan - (IDW+1)'(NREQ);
                end
                if (!found && req_valid[scan[IDW-1:0]]) begin
                    found   = 1'b1;
                    gnt_idx = scan[IDW-1:0];
                end
            end
        end
    end

    assign req_ready = found ? (NREQ'(1) << gnt_idx) : '0;
    assign ptr_next  = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] op_b_eff;
    logic [1:0]   op_ctl;
    logic         op_sub;
    logic [N-1:0] alu_result;

    assign op_a     = req_a[gnt_idx*N +: N];
    assign op_b     = req_b[gnt_idx*N +: N];
    assign op_ctl   = req_ctl[gnt_idx*2 +: 2];
    assign op_sub   = (op_ctl == 2'b01);
    assign op_b_eff = op_sub ? ~op_b : op_b;

`ifdef ALU_ARB_FLAGS_EN
    logic [N:0] sum;
    logic       op_arith;
    logic [3:0] alu_flags;

    assign sum      = {1'b0, op_a} + {1'b0, op_b_eff} + {{N{1'b0}}, op_sub};
    assign op_arith = !op_ctl[1];
`else
    logic [N-1:0] sum;

    assign sum = op_a + op_b_eff + {{(N-1){1'b0}}, op_sub};
`endif

    always_comb begin
        case (op_ctl)
            2'b10:   alu_result = op_a & op_b;
            2'b11:   alu_result = op_a | op_b;
            default: alu_result = sum[N-1:0];
        endcase
    end

`ifdef ALU_ARB_FLAGS_EN
    assign alu_flags = {alu_result[N-1],
                        (alu_result == '0),
                        op_arith & sum[N],
                        op_arith & (op_a[N-1] == op_b_eff[N-1]) & (alu_result[N-1] != op_a[N-1])};
`endif

    // An accept always overwrites the slot, which covers the drain-and-accept case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            ptr        <= '0;
            rsp_result <= '0;
            rsp_id     <= '0;
`ifdef ALU_ARB_FLAGS_EN
            rsp_flags  <= '0;
`endif
        end else if (found) begin
            state      <= FULL;
            ptr        <= ptr_next;
            rsp_result <= alu_result;
            rsp_id     <= gnt_idx;
`ifdef ALU_ARB_FLAGS_EN
            rsp_flags  <= alu_flags;
`endif
        end else if (state == FULL && rsp_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences, randomized run vs reference model.
// Flag checks are compiled in when ALU_ARB_FLAGS_EN is defined.
module tb_alu_arbiter;

    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic [NREQ*2-1:0]   req_ctl;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [N-1:0]        rsp_result;
    logic [IDW-1:0]      rsp_id;
`ifdef ALU_ARB_FLAGS_EN
    logic [3:0]          rsp_flags;
`endif

    alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctl    (req_ctl),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id)
`ifdef ALU_ARB_FLAGS_EN
        ,
        .rsp_flags  (rsp_flags)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    bit          mvalid;
    int          mptr;
    logic [31:0] mres;
    int          mid;
`ifdef ALU_ARB_FLAGS_EN
    logic [3:0]  mflg;
`endif

    typedef struct {
        int          ridx;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctl;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [1:0] ctl);
        case (ctl)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [3:0] model_flags(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] ctl);
        logic [31:0] r;
        longint      sa;
        longint      sb;
        longint      sr;
        longint unsigned us;
        logic        c;
        logic        v;
        r  = model_result(a, b, ctl);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        if (ctl == 2'b00) begin
            us = {32'b0, a} + {32'b0, b};
            c  = us[32];
            sr = sa + sb;
            v  = (sr > SMAX) || (sr < SMIN);
        end else if (ctl == 2'b01) begin
            c  = (a >= b);
            sr = sa - sb;
            v  = (sr > SMAX) || (sr < SMIN);
        end
        return {r[31], (r == 32'd0), c, v};
    endfunction

    function automatic int model_grant();
        if (!reset_n) return -1;
        if (mvalid && !rsp_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mvalid = 1'b0;
        mptr   = 0;
        mres   = '0;
        mid    = 0;
`ifdef ALU_ARB_FLAGS_EN
        mflg   = '0;
`endif
    endtask

    // Called just after a falling edge with inputs driven; checks grant, clocks once, checks slot.
    task automatic cycle();
        int         g;
        logic [3:0] er;
        #1;
        g  = model_grant();
        er = (g >= 0) ? 4'(1 << g) : 4'b0;
        chk("req_ready", {60'b0, req_ready}, {60'b0, er});
        @(posedge clk);
        if (g >= 0) begin
            mres   = model_result(req_a[g*32 +: 32], req_b[g*32 +: 32], req_ctl[g*2 +: 2]);
`ifdef ALU_ARB_FLAGS_EN
            mflg   = model_flags(req_a[g*32 +: 32], req_b[g*32 +: 32], req_ctl[g*2 +: 2]);
`endif
            mid    = g;
            mvalid = 1'b1;
            mptr   = (g + 1) % NREQ;
        end else if (mvalid && rsp_ready) begin
            mvalid = 1'b0;
        end
        @(negedge clk);
        chk("rsp_valid", {63'b0, rsp_valid}, {63'b0, mvalid});
        chk("rsp_result", {32'b0, rsp_result}, {32'b0, mres});
        chk("rsp_id", {62'b0, rsp_id}, 64'(mid));
`ifdef ALU_ARB_FLAGS_EN
        chk("rsp_flags", {60'b0, rsp_flags}, {60'b0, mflg});
`endif
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctl);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_ctl[i*2 +: 2] = ctl;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 32'd5,          32'd3, 2'b00, 32'd8,          4'b0000};
        vecs[1] = '{1, 32'd3,          32'd5, 2'b01, 32'hFFFF_FFFE, 4'b1000};
        vecs[2] = '{3, 32'h8000_0000,  32'd1, 2'b01, 32'h7FFF_FFFF, 4'b0011};
        vecs[3] = '{0, 32'h0000_00F0,  32'h0000_000F, 2'b11, 32'h0000_00FF, 4'b0000};
        vecs[4] = '{2, 32'hFFFF_FFFF,  32'd1, 2'b00, 32'd0,          4'b0110};
        vecs[5] = '{1, 32'h0000_00F0,  32'h0000_000F, 2'b10, 32'd0,  4'b0100};
        vecs[6] = '{0, 32'h7FFF_FFFF,  32'd1, 2'b00, 32'h8000_0000, 4'b1001};
        vecs[7] = '{3, 32'd5,          32'd5, 2'b01, 32'd0,          4'b0110};
        vecs[8] = '{2, 32'd0,          32'd1, 2'b01, 32'hFFFF_FFFF, 4'b1000};

        // Reset held with every requester asking
        model_reset();
        reset_n   = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_ctl   = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'(i), 2'b00);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_req_ready", {60'b0, req_ready}, 64'd0);
        chk("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("reset_rsp_result", {32'b0, rsp_result}, 64'd0);
        chk("reset_rsp_id", {62'b0, rsp_id}, 64'd0);
`ifdef ALU_ARB_FLAGS_EN
        chk("reset_rsp_flags", {60'b0, rsp_flags}, 64'd0);
`endif
        reset_n = 1'b1;
        #1;
        chk("first_grant", {60'b0, req_ready}, 64'b0001);
        cycle();

        // Round robin from a fresh reset: ids 0,1,2,3,0 back to back
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_id", {62'b0, rsp_id}, 64'(k % NREQ));
            chk("rr_valid", {63'b0, rsp_valid}, 64'd1);
        end

        // Vector table: one requester at a time, consumer always ready
        for (int t = 0; t < 9; t++) begin
            req_valid = '0;
            req_valid[vecs[t].ridx] = 1'b1;
            set_req(vecs[t].ridx, vecs[t].a, vecs[t].b, vecs[t].ctl);
            rsp_ready = 1'b1;
            #1;
            chk("vec_grant", {60'b0, req_ready}, 64'(1 << vecs[t].ridx));
            cycle();
            chk("vec_result", {32'b0, rsp_result}, {32'b0, vecs[t].res});
            chk("vec_id", {62'b0, rsp_id}, 64'(vecs[t].ridx));
`ifdef ALU_ARB_FLAGS_EN
            chk("vec_flags", {60'b0, rsp_flags}, {60'b0, vecs[t].flg});
`endif
        end

        // Backpressure: slot full, consumer stalled for 3 cycles, requester 1 waiting
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_req(1, 32'd10, 32'd20, 2'b00);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_no_grant", {60'b0, req_ready}, 64'd0);
            cycle();
            chk("bp_hold_result", {32'b0, rsp_result}, {32'b0, vecs[8].res});
            chk("bp_hold_id", {62'b0, rsp_id}, 64'(vecs[8].ridx));
            chk("bp_hold_valid", {63'b0, rsp_valid}, 64'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", {60'b0, req_ready}, 64'b0010);
        cycle();
        chk("bp_release_id", {62'b0, rsp_id}, 64'd1);
        chk("bp_release_result", {32'b0, rsp_result}, 64'd30);

        // Reset while a result is pending
        req_valid = 4'b0100;
        set_req(2, 32'h0000_00F0, 32'h0000_000F, 2'b11);
        cycle();
        chk("midrst_pre_result", {32'b0, rsp_result}, 64'h0FF);
        rsp_ready = 1'b0;
        req_valid = '0;
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_valid", {63'b0, rsp_valid}, 64'd0);
        chk("midrst_result", {32'b0, rsp_result}, 64'd0);
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        chk("midrst_ptr0_grant", {60'b0, req_ready}, 64'b0001);
        cycle();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, rand_operand(), rand_operand(), 2'($urandom_range(0, 3)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
